maxunpool1d: RTL and testbench

MAXUNPOOL1D -- requirements
Module: maxunpool1d

---
 rtl/cnn_pkg.sv | 17 +
 rtl/unpool_lane.sv | 35 +++
 rtl/maxunpool1d.sv | 138 +++++++++++++
 tb/tb_maxunpool1d.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN block definitions: index-width helper, unpool FSM encoding, default widths.
package cnn_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_CHANNELS   = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        EMIT  = 1'b1
    } state_t;

    // Bits needed to address a position inside a pooling window (never less than 1).
    function automatic int idx_w(input int kernel_width);
        return (kernel_width > 2) ? $clog2(kernel_width) : 1;
    endfunction

endpackage

// File: rtl/unpool_lane.sv
// One channel of max-unpooling: routes the held value to the sub-position named by its argmax index.
// With MAXUNPOOL_NEAREST_EN defined, a nearest input replicates the value to every sub-position.
module unpool_lane
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int KERNEL_WIDTH = 2,
    localparam int IDX_W       = idx_w(KERNEL_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [IDX_W-1:0]      idx,
    input  logic [IDX_W-1:0]      sub,
`ifdef MAXUNPOOL_NEAREST_EN
    input  logic                  nearest,
`endif
    output logic [DATA_WIDTH-1:0] sample
);

    // One extra bit so a power-of-two window size is representable.
    localparam logic [IDX_W:0] K_LIM = (IDX_W + 1)'(KERNEL_WIDTH);

    logic idx_in_range;
    logic hit;

    assign idx_in_range = ({1'b0, idx} < K_LIM);

`ifdef MAXUNPOOL_NEAREST_EN
    assign hit = nearest || (idx_in_range && (idx == sub));
`else
    assign hit = idx_in_range && (idx == sub);
`endif

    assign sample = hit ? value : '0;

endmodule

// File: rtl/maxunpool1d.sv
// 1-D max-unpooling stream block: each pooled beat expands into KERNEL_WIDTH output beats.
// Optional MAXUNPOOL_NEAREST_EN adds a nearest port for nearest-neighbour upsampling.
module maxunpool1d
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CHANNELS     = DEFAULT_CHANNELS,
    parameter int KERNEL_WIDTH = 2,
    parameter int OUT_LEN      = 16,
    localparam int IDX_W       = idx_w(KERNEL_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH*CHANNELS-1:0] in_data,
    input  logic [IDX_W*CHANNELS-1:0]      in_idx,
    input  logic                           in_last,
`ifdef MAXUNPOOL_NEAREST_EN
    input  logic                           nearest,
`endif
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH*CHANNELS-1:0] out_data,
    output logic                           out_last,
    output logic                           frame_err,
    output state_t                         fsm_state
);

    localparam int BEATS  = OUT_LEN / KERNEL_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  SUB_LAST  = IDX_W'(KERNEL_WIDTH - 1);

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               sub_q, sub_d;
    logic [BEAT_W-1:0]              beat_cnt_q;
    logic [DATA_WIDTH*CHANNELS-1:0] hold_data_q;
    logic [IDX_W*CHANNELS-1:0]      hold_idx_q;
    logic                           hold_last_q;
    logic                           frame_err_q;
`ifdef MAXUNPOOL_NEAREST_EN
    logic                           hold_nearest_q;
`endif

    logic in_fire;
    logic out_fire;
    logic sub_end;
    logic beat_is_final;

    // Handshake: a beat moves on a side when its valid and ready are both high at the
    // rising edge; in_ready never looks at in_valid, and out_data/out_last only change
    // on an output transfer, so they hold steady while out_valid waits on out_ready.
    assign sub_end       = (sub_q == SUB_LAST);
    assign beat_is_final = (beat_cnt_q == BEAT_LAST);
    assign out_valid     = (state_q == EMIT);
    assign in_ready      = (state_q == EMPTY) || (out_ready && sub_end);
    assign in_fire       = in_valid && in_ready;
    assign out_fire      = out_valid && out_ready;
    assign out_last      = out_valid && sub_end && hold_last_q;
    assign frame_err     = frame_err_q;
    assign fsm_state     = state_q;

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = EMIT;
                    sub_d   = '0;
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (sub_end) begin
                        // Refill on the same edge keeps the stream free of bubbles.
                        sub_d   = '0;
                        state_d = in_fire ? EMIT : EMPTY;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                sub_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= EMPTY;
            sub_q          <= '0;
            beat_cnt_q     <= '0;
            hold_data_q    <= '0;
            hold_idx_q     <= '0;
            hold_last_q    <= 1'b0;
            frame_err_q    <= 1'b0;
`ifdef MAXUNPOOL_NEAREST_EN
            hold_nearest_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            if (in_fire) begin
                hold_data_q <= in_data;
                hold_idx_q  <= in_idx;
                hold_last_q <= beat_is_final;
                beat_cnt_q  <= beat_is_final ? '0 : beat_cnt_q + 1'b1;
`ifdef MAXUNPOOL_NEAREST_EN
                hold_nearest_q <= nearest;
`endif
                // The count is trusted over in_last; a disagreement is only flagged.
                if (in_last != beat_is_final) begin
                    frame_err_q <= 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        unpool_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .KERNEL_WIDTH(KERNEL_WIDTH)
        ) u_lane (
            .value  (hold_data_q[c*DATA_WIDTH +: DATA_WIDTH]),
            .idx    (hold_idx_q[c*IDX_W +: IDX_W]),
            .sub    (sub_q),
`ifdef MAXUNPOOL_NEAREST_EN
            .nearest(hold_nearest_q),
`endif
            .sample (out_data[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_maxunpool1d.sv
// Directed bench for maxunpool1d (4 channels x 16 bits, window 2, 16-beat frames).
// Covers the MAXUNPOOL_NEAREST_EN build as well when that macro is defined.
module tb_maxunpool1d;
    import cnn_pkg::*;

    localparam int DW = 16;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_data = '0;
    logic [3:0]    in_idx = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [63:0]   out_data;
    logic          out_last;
    logic          frame_err;
    state_t        fsm_state;
`ifdef MAXUNPOOL_NEAREST_EN
    logic          nearest = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic exp_err = 1'b0;
    logic [64:0] exp_q[$];

    maxunpool1d #(
        .DATA_WIDTH  (DW),
        .CHANNELS    (CH),
        .KERNEL_WIDTH(2),
        .OUT_LEN     (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_idx   (in_idx),
        .in_last  (in_last),
`ifdef MAXUNPOOL_NEAREST_EN
        .nearest  (nearest),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .frame_err(frame_err),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] observed, input logic [64:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] beat_data(input int b);
        logic [63:0] d;
        for (int c = 0; c < CH; c++) d[c*DW +: DW] = 16'((b << 8) | (c << 4) | (b + c + 1));
        return d;
    endfunction

    function automatic logic [3:0] beat_idx(input int b);
        return 4'(b * 7 + 5);
    endfunction

    // Expected output beat at window position p for a pooled beat.
    function automatic logic [64:0] model_beat(input logic [63:0] d, input logic [3:0] idx,
                                               input int p, input logic last);
        logic [63:0] o;
        for (int c = 0; c < CH; c++) o[c*DW +: DW] = (int'(idx[c]) == p) ? d[c*DW +: DW] : 16'h0;
        return {last, o};
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_state", fsm_state, EMPTY);
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
    endtask

    // Streams nbeats pooled beats with in_valid held high; optional out_ready stall.
    task automatic run_stream(input int nbeats, input int last_at, input int stall_at, input int stall_len);
        int nb = 0;
        int out_cnt = 0;
        int stall_left = stall_len;
        int gaps = 0;
        int first_out = -1;
        logic [64:0] e;
        exp_q.delete();
        for (int cyc = 0; cyc < 200 && (nb < nbeats || out_cnt < nbeats * 2); cyc++) begin
            @(negedge clk);
            in_valid  = (nb < nbeats);
            in_data   = beat_data(nb);
            in_idx    = beat_idx(nb);
            in_last   = (nb == last_at);
            out_ready = !(out_cnt == stall_at && stall_left > 0);
            #1;
            chk("frame_err", frame_err, exp_err);
            if (out_valid && first_out < 0) first_out = cyc;
            if (!out_ready) begin
                if (out_valid) stall_left--;
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                if (exp_q.size() > 0) begin
                    chk("stall_out_data", out_data, exp_q[0][63:0]);
                    chk("stall_out_last", out_last, exp_q[0][64]);
                end else chk("stall_queue", exp_q.size(), 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("out_queue", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[63:0]);
                    chk("out_last", out_last, e[64]);
                end
                out_cnt++;
            end else if (first_out >= 0 && !out_valid && out_cnt < nbeats * 2) gaps++;
            if (in_valid && in_ready) begin
                exp_q.push_back(model_beat(in_data, in_idx, 0, 1'b0));
                exp_q.push_back(model_beat(in_data, in_idx, 1, (nb % 8) == 7));
                if (in_last != ((nb % 8) == 7)) exp_err = 1'b1;
                nb++;
            end
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        chk("beats_in", nb, nbeats);
        chk("beats_out", out_cnt, nbeats * 2);
        chk("first_latency", first_out, 1);
        chk("bubbles", gaps, 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        reset_dut();

        // Single beat: ch0=0x1234 idx 1, ch1=0x00FF idx 0
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {16'h0000, 16'h0000, 16'h00FF, 16'h1234};
        in_idx   = 4'b0001;
        in_last  = 1'b0;
        #1;
        chk("t1_in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t1_b0_valid", out_valid, 1);
        chk("t1_b0_ch0", out_data[15:0], 16'h0000);
        chk("t1_b0_ch1", out_data[31:16], 16'h00FF);
        chk("t1_b0_in_ready", in_ready, 0);
        chk("t1_b0_last", out_last, 0);
        @(negedge clk);
        #1;
        chk("t1_b1_valid", out_valid, 1);
        chk("t1_b1_ch0", out_data[15:0], 16'h1234);
        chk("t1_b1_ch1", out_data[31:16], 16'h0000);
        chk("t1_b1_in_ready", in_ready, 1);
        @(negedge clk);
        #1;
        chk("t1_idle_valid", out_valid, 0);
        chk("t1_idle_state", fsm_state, EMPTY);

        // Full frame back to back
        reset_dut();
        run_stream(8, 7, -1, 0);

        // Output stall of 5 cycles on a sub=1 beat
        reset_dut();
        run_stream(8, 7, 5, 5);

        // in_last on the 4th beat: sticky frame error
        reset_dut();
        run_stream(8, 3, -1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("err_sticky", frame_err, 1);
        end
        reset_dut();

        // Reset while emitting beat 3 at sub=0, then a clean frame
        run_stream(3, -1, -1, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = beat_data(3);
        in_idx   = beat_idx(3);
        #1;
        chk("r_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("r_pre_valid", out_valid, 1);
        chk("r_pre_state", fsm_state, EMIT);
        rst_n = 1'b0;
        #1;
        chk("r_async_valid", out_valid, 0);
        chk("r_async_data", out_data, 0);
        chk("r_async_state", fsm_state, EMPTY);
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 1'b0;
        run_stream(8, 7, -1, 0);

`ifdef MAXUNPOOL_NEAREST_EN
        // Nearest-neighbour upsample ignores the index
        reset_dut();
        @(negedge clk);
        in_valid = 1'b1;
        nearest  = 1'b1;
        in_data  = {48'h0, 16'h0A0A};
        in_idx   = 4'b0000;
        @(negedge clk);
        in_valid = 1'b0;
        nearest  = 1'b0;
        #1;
        chk("n_b0_ch0", out_data[15:0], 16'h0A0A);
        @(negedge clk);
        #1;
        chk("n_b1_ch0", out_data[15:0], 16'h0A0A);
        chk("n_b1_valid", out_valid, 1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
